// File: rtl/rank_filter_pkg.sv
// Shared constants for the 3x3 rank filter: mode encodings and parameter defaults.
package rank_filter_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CH        = 3;
  localparam int DEF_PIC_WIDTH = 250;

  localparam logic [1:0] MODE_MED = 2'd0;
  localparam logic [1:0] MODE_MIN = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;
  localparam logic [1:0] MODE_BYP = 2'd3;

endpackage

// File: rtl/sort3_unit.sv
// Combinational unsigned sort of three values into lo/mid/hi.
module sort3_unit
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] hi
);

  logic [DATA_W-1:0] ab_lo, ab_hi;

  always_comb begin
    ab_lo = (a < b) ? a : b;
    ab_hi = (a < b) ? b : a;
    lo    = (ab_lo < c) ? ab_lo : c;
    hi    = (ab_hi > c) ? ab_hi : c;
    if (c < ab_lo)
      mid = ab_lo;
    else if (c > ab_hi)
      mid = ab_hi;
    else
      mid = c;
  end

endmodule

// File: rtl/rank_filter_3x3.sv
// 3x3 per-channel rank filter (median/min/max/bypass), three-stage pipeline.
// Output k is centred on image column k-1; the first two columns of a line pass the centre pixel.
module rank_filter_3x3
  import rank_filter_pkg::*;
#(
  parameter int PIC_WIDTH = DEF_PIC_WIDTH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CH        = DEF_CH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sol,
  input  logic [1:0]           mode,
  input  logic [CH*DATA_W-1:0] din1,
  input  logic [CH*DATA_W-1:0] din2,
  input  logic [CH*DATA_W-1:0] din3,
  output logic [CH*DATA_W-1:0] dout,
  output logic                 valid_out
);

  localparam int PW    = CH * DATA_W;
  localparam int COL_W = $clog2(PIC_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);

  logic [COL_W-1:0]   col, col_cur, col_nxt;
  logic [PW-1:0]      n_lo, n_mid, n_hi;
  logic [2:0][PW-1:0] s_lo, s_mid, s_hi;
  logic [PW-1:0]      win_ctr;
  logic               v1, bord1, v2, bord2;
  logic [1:0]         mode1, mode2;
  logic [PW-1:0]      ctr1, ctr2;
  logic [PW-1:0]      mxmin_c, mdmid_c, mnmax_c, gmin_c, gmax_c;
  logic [PW-1:0]      mxmin2, mdmid2, mnmax2, gmin2, gmax2;
  logic [PW-1:0]      med_c, dout_nxt;

  // Index 0 of s_* is the newest column; channels never compare across their slice.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    localparam int LSB = g * DATA_W;
    logic [DATA_W-1:0] lo_mid, mid_lo, mid_hi, hi_mid, med_lo, med_hi;

    sort3_unit #(.DATA_W(DATA_W)) u_col (
      .a(din1[LSB +: DATA_W]), .b(din2[LSB +: DATA_W]), .c(din3[LSB +: DATA_W]),
      .lo(n_lo[LSB +: DATA_W]), .mid(n_mid[LSB +: DATA_W]), .hi(n_hi[LSB +: DATA_W])
    );
    sort3_unit #(.DATA_W(DATA_W)) u_lo (
      .a(s_lo[0][LSB +: DATA_W]), .b(s_lo[1][LSB +: DATA_W]), .c(s_lo[2][LSB +: DATA_W]),
      .lo(gmin_c[LSB +: DATA_W]), .mid(lo_mid), .hi(mxmin_c[LSB +: DATA_W])
    );
    sort3_unit #(.DATA_W(DATA_W)) u_mid (
      .a(s_mid[0][LSB +: DATA_W]), .b(s_mid[1][LSB +: DATA_W]), .c(s_mid[2][LSB +: DATA_W]),
      .lo(mid_lo), .mid(mdmid_c[LSB +: DATA_W]), .hi(mid_hi)
    );
    sort3_unit #(.DATA_W(DATA_W)) u_hi (
      .a(s_hi[0][LSB +: DATA_W]), .b(s_hi[1][LSB +: DATA_W]), .c(s_hi[2][LSB +: DATA_W]),
      .lo(mnmax_c[LSB +: DATA_W]), .mid(hi_mid), .hi(gmax_c[LSB +: DATA_W])
    );
    sort3_unit #(.DATA_W(DATA_W)) u_med (
      .a(mxmin2[LSB +: DATA_W]), .b(mdmid2[LSB +: DATA_W]), .c(mnmax2[LSB +: DATA_W]),
      .lo(med_lo), .mid(med_c[LSB +: DATA_W]), .hi(med_hi)
    );
  end

  always_comb begin
    col_cur  = sol ? '0 : col;
    col_nxt  = (col_cur == COL_LAST) ? '0 : col_cur + COL_W'(1);
    dout_nxt = ctr2;
    if (!bord2) begin
      case (mode2)
        MODE_MED: dout_nxt = med_c;
        MODE_MIN: dout_nxt = gmin2;
        MODE_MAX: dout_nxt = gmax2;
        default:  dout_nxt = ctr2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      s_lo      <= '0;
      s_mid     <= '0;
      s_hi      <= '0;
      win_ctr   <= '0;
      v1        <= 1'b0;
      bord1     <= 1'b0;
      mode1     <= '0;
      ctr1      <= '0;
      v2        <= 1'b0;
      bord2     <= 1'b0;
      mode2     <= '0;
      ctr2      <= '0;
      mxmin2    <= '0;
      mdmid2    <= '0;
      mnmax2    <= '0;
      gmin2     <= '0;
      gmax2     <= '0;
      dout      <= '0;
      valid_out <= 1'b0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        col     <= col_nxt;
        s_lo    <= {s_lo[1:0], n_lo};
        s_mid   <= {s_mid[1:0], n_mid};
        s_hi    <= {s_hi[1:0], n_hi};
        win_ctr <= din2;
        ctr1    <= win_ctr;
        mode1   <= mode;
        bord1   <= (col_cur < COL_W'(2));
      end
      // Later stages run every cycle so accepted pixels drain during input gaps.
      v2        <= v1;
      bord2     <= bord1;
      mode2     <= mode1;
      ctr2      <= ctr1;
      mxmin2    <= mxmin_c;
      mdmid2    <= mdmid_c;
      mnmax2    <= mnmax_c;
      gmin2     <= gmin_c;
      gmax2     <= gmax_c;
      valid_out <= v2;
      if (v2)
        dout <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_rank_filter_3x3.sv
// Directed bench for rank_filter_3x3 with PIC_WIDTH = 4 and hand-computed outputs.
module tb_rank_filter_3x3;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n, valid_in, sol, valid_out;
  logic [1:0]    mode;
  logic [PW-1:0] din1, din2, din3, dout;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  rank_filter_3x3 #(.PIC_WIDTH(4), .DATA_W(8), .CH(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sol(sol), .mode(mode),
    .din1(din1), .din2(din2), .din3(din3), .dout(dout), .valid_out(valid_out)
  );

  typedef struct {
    bit v; bit s; logic [1:0] md;
    logic [7:0] t; logic [7:0] m; logic [7:0] b;
    bit r; logic [PW-1:0] e;
  } stim_t;

  stim_t         stim[$];
  logic [PW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ch0 = v, ch1 = 0xFF, ch2 = 10-v (reversed order) or 0
  function automatic logic [PW-1:0] pix(logic [7:0] v, bit r);
    return {r ? 8'(8'd10 - v) : 8'h00, 8'hFF, v};
  endfunction

  task automatic drive(bit v, bit s, logic [1:0] md, logic [7:0] t, logic [7:0] m,
                       logic [7:0] b, bit r);
    valid_in = v; sol = s; mode = md;
    din1 = pix(t, r); din2 = pix(m, r); din3 = pix(b, r);
  endtask

  task automatic check(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add(bit v, bit s, logic [1:0] md, logic [7:0] t, logic [7:0] m,
                     logic [7:0] b, bit r, logic [PW-1:0] e);
    stim_t x;
    x.v = v; x.s = s; x.md = md; x.t = t; x.m = m; x.b = b; x.r = r; x.e = e;
    stim.push_back(x);
  endtask

  stim_t x;
  bit    h0, h1;
  int    n_in, n_out;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("reset_vout", {23'b0, valid_out}, '0);
    check("reset_dout", dout, '0);
    rst_n = 1'b1;

    // A={3,7,1} B={9,5,2} C={8,4,6} D={2,4,8}; four lines of A B C D
    add(1,0,1, 3,7,1, 0, 24'h000000); add(1,0,2, 9,5,2, 0, 24'h00FF07);
    add(1,0,0, 8,4,6, 0, 24'h00FF05); add(1,0,3, 2,4,8, 0, 24'h00FF04);
    add(1,0,1, 3,7,1, 1, 24'h00FF04); add(1,0,2, 9,5,2, 1, 24'h03FF07);
    add(1,0,1, 8,4,6, 1, 24'h01FF01); add(1,0,3, 2,4,8, 1, 24'h06FF04);
    add(1,0,1, 3,7,1, 1, 24'h06FF04); add(1,0,2, 9,5,2, 1, 24'h03FF07);
    add(1,0,2, 8,4,6, 1, 24'h09FF09); add(1,0,3, 2,4,8, 1, 24'h06FF04);
    add(1,0,1, 3,7,1, 1, 24'h06FF04); add(1,0,2, 9,5,2, 1, 24'h03FF07);
    add(1,0,3, 8,4,6, 1, 24'h05FF05); add(1,0,3, 2,4,8, 1, 24'h06FF04);
    // sol at what would be col 2 restarts the border
    add(1,0,0, 3,7,1, 0, 24'h06FF04); add(1,0,0, 9,5,2, 0, 24'h00FF07);
    add(1,1,1, 8,4,6, 0, 24'h00FF05); add(1,0,2, 3,7,1, 0, 24'h00FF04);
    add(1,0,1, 9,5,2, 0, 24'h00FF01);
    // input gaps carry garbage data and an unqualified sol
    add(1,0,0, 8,4,6, 0, 24'h00FF05); add(1,0,0, 3,7,1, 0, 24'h00FF04);
    add(0,1,2, 8'hEE,8'hEE,8'hEE, 1, '0); add(0,1,2, 8'hEE,8'hEE,8'hEE, 1, '0);
    add(1,0,0, 9,5,2, 0, 24'h00FF07); add(1,0,2, 8,4,6, 0, 24'h00FF09);
    add(0,1,2, 8'hEE,8'hEE,8'hEE, 1, '0);
    add(1,0,1, 3,7,1, 0, 24'h00FF01);

    h0 = 1'b0; h1 = 1'b0; n_in = 0; n_out = 0;
    for (int i = 0; i < stim.size() + 3; i++) begin
      if (i < stim.size()) begin
        x = stim[i];
        drive(x.v, x.s, x.md, x.t, x.m, x.b, x.r);
        if (x.v) begin
          exp_q.push_back(x.e);
          n_in++;
        end
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
      end
      tick();
      check($sformatf("vout_step%0d", i), {23'b0, valid_out}, {23'b0, h1});
      if (valid_out) n_out++;
      if (h1 && exp_q.size() > 0)
        check($sformatf("dout_step%0d", i), dout, exp_q.pop_front());
      h1 = h0;
      h0 = (i < stim.size()) ? stim[i].v : 1'b0;
    end
    check("out_count", PW'(n_out), PW'(n_in));

    // reset with two pixels in flight
    drive(1, 0, 0, 3, 7, 1, 0); tick();
    drive(1, 0, 0, 9, 5, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_vout0", {23'b0, valid_out}, '0);
    check("rst_dout0", dout, '0);
    tick();
    check("rst_vout1", {23'b0, valid_out}, '0);
    check("rst_dout1", dout, '0);
    tick();
    check("rst_vout2", {23'b0, valid_out}, '0);
    check("rst_dout2", dout, '0);
    drive(1, 0, 2, 8, 4, 6, 0); tick();
    drive(1, 0, 1, 3, 7, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("post_rst_vout0", {23'b0, valid_out}, 24'h1);
    check("post_rst_dout0", dout, 24'h000000);
    tick();
    check("post_rst_vout1", {23'b0, valid_out}, 24'h1);
    check("post_rst_dout1", dout, 24'h00FF04);
    tick();
    check("post_rst_vout2", {23'b0, valid_out}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rank_filter_3x3.md
RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

Interface
REQ-001 PIC_WIDTH, 250, pixels per line; legal range 3..2047.
REQ-002 DATA_W, 8, bits per colour channel.
REQ-003 CH, 3, channels per pixel; pixel bus width PW = CH*DATA_W, with channel n at bits [n*DATA_W +: DATA_W].
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 valid_in  in  1  din1..din3, mode and sol are sampled when this is high.
REQ-007 sol  in  1  start of line; qualified by valid_in.
REQ-008 mode  in  2  0 = median, 1 = minimum, 2 = maximum, 3 = bypass centre.
REQ-009 din1/din2/din3  in  PW each  one column of three vertically adjacent pixels (top, centre, bottom rows).
REQ-010 dout  out  PW  filtered pixel.
REQ-011 valid_out  out  1  dout is valid this cycle.

Function
REQ-012 The block shall filter each channel independently, using unsigned comparisons; no comparison shall ever span the full PW bus.
REQ-013 On each valid_in, the block shall shift a 3-column window: newest column k, then k-1, then k-2; the window centre is pixel din2 of column k-1.
REQ-014 The block shall emit exactly one output per accepted input; output k belongs to image column k-1 (one-pixel spatial offset, fixed and documented).
REQ-015 Latency: valid_out shall be high exactly 3 clk cycles after a cycle with valid_in high; otherwise valid_out shall be low.
REQ-016 Stage 1 (acceptance edge): sort the newest column per channel into min/mid/max; register the window, sorted triples, centre pixel, mode and border flag.
REQ-017 Stage 2: compute per channel max-of-mins, median-of-mids, min-of-maxes, global min and global max.
REQ-018 Stage 3: the block shall register into dout the median of the three stage-2 values (mode 0), the global min (mode 1), the global max (mode 2), or the centre pixel (mode 3).
REQ-019 mode shall travel in the pipeline with its pixel; a mode change affects only pixels accepted after the change.
REQ-020 Column counter col, width clog2(PIC_WIDTH): increments on valid_in, and wraps from PIC_WIDTH-1 to 0.
REQ-021 sol together with valid_in shall load col as 0 for that pixel; sol overrides wrap, and simultaneous sol and wrap give col = 0.
REQ-022 Border flag shall be set when col < 2 at acceptance; a bordered output shall equal the centre pixel regardless of mode.
REQ-023 When valid_in is low, the window, sorted triples and col shall hold; pipeline stages 2-3 keep advancing, so in-flight pixels drain.
REQ-024 Equal values (ties) shall give a value-deterministic result, independent of which input carried them.

Reset
REQ-025 When rst_n is low at a clock edge, the block shall clear dout, valid_out, the window, the sorted triples, the pipeline valids, the modes and col to 0.
REQ-026 Reset mid-line shall discard in-flight pixels: valid_out is low on the first edge after reset.
REQ-027 The first two pixels after reset shall be treated as border (col restarts at 0).

Structure
REQ-028 A shared package rank_filter_pkg shall hold the mode constants (MODE_MED, MODE_MIN, MODE_MAX, MODE_BYP) and the defaults for DATA_W, CH and PIC_WIDTH.
REQ-029 A sub-module sort3_unit (DATA_W parameter, combinational 3-input min/mid/max) shall be used for column sorting and the stage-2/3 median-of-three, instantiated per channel via generate.

Verification
REQ-030 Centre channel 0 columns {3,7,1},{9,5,2},{8,4,6} at col >= 2, mode 0: dout ch0 = 5, 3 cycles after the third column.
REQ-031 Same window, mode 1 then mode 2 on successive pixels: dout = 1 then 9 respectively; mode 3: dout = 5 (centre pixel).
REQ-032 Channels differ, e.g. ch0 window 1..9, ch1 all 0xFF, ch2 all 0x00, mode 0: dout = {0x00, 0xFF, 0x05}, proving per-channel operation.
REQ-033 PIC_WIDTH = 4, continuous valid_in: valid_out high 3 cycles after each input, and outputs at col 0,1 equal the centre pixel; sol asserted at col = 2 restarts the border.
REQ-034 valid_in toggled 1-0-0-1 mid-line: the window holds, no output is lost or duplicated, and the output count equals the input count.
REQ-035 rst_n low for 1 cycle with 2 pixels in flight: valid_out low next edge, and dout = 0 until a new valid output.
